multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and reset (in, 1, synchronous, active-high); one clock, synchronous active-high reset.
REQ-002 SHALL have Opcode (in, 6, instruction bits [31:26], sampled in DECODE) and MemReady (in, 1, memory access complete this cycle).
REQ-003 SHALL have PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst and RegWrite (each out, 1): datapath strobes and mux selects.
REQ-004 SHALL have ALUSrcA (out, 1: 0=PC, 1=regA), ALUSrcB (out, 2: 00=regB, 01=const 4, 10=sign-ext imm, 11=imm<<2), ALUOp (out, 2: 00 add, 01 sub, 10 funct-decoded), PCSource (out, 2: 00 ALU, 01 ALUOut, 10 jump target).
REQ-005 SHALL have IllegalOp (out, 1, one-cycle pulse) and State (out, 4, current state code for debug).

Function
REQ-006 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEXEC=10, ADDIWB=11; codes 12-15 unreachable and SHALL go to FETCH.
REQ-007 SHALL drive every output not listed for a state to 0.
REQ-008 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite SHALL equal MemReady; SHALL hold in FETCH while MemReady=0, else go to DECODE.
REQ-009 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and branch on Opcode: 000000->EXECUTE, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEXEC.
REQ-010 DECODE with any other Opcode SHALL assert IllegalOp for that cycle and go to FETCH; no register or memory write SHALL occur.
REQ-011 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMREAD if Opcode=100011, else MEMWRITE.
REQ-012 MEMREAD SHALL drive MemRead=1, IorD=1; hold while MemReady=0, else go to MEMWB.
REQ-013 MEMWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-014 MEMWRITE SHALL drive MemWrite=1, IorD=1; hold while MemReady=0, else go to FETCH.
REQ-015 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RTYPEWB.
REQ-016 RTYPEWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-017 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-018 JUMP SHALL drive PCWrite=1, PCSource=10; next FETCH.
REQ-019 ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB. ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-020 Opcode SHALL be consumed only in DECODE and MEMADR (IR is stable after FETCH); changes at other times SHALL have no effect.
REQ-021 Latency at MemReady=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each wait cycle adds exactly one.

Reset
REQ-022 reset=1 at a rising edge SHALL force State=FETCH regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-023 While reset=1, all 1-bit outputs SHALL be 0 and all multi-bit outputs 0, including MemRead and IRWrite; FETCH outputs SHALL appear from the first cycle after reset deasserts.

Structure
REQ-024 Opcode constants, state codes, and ALUOp/ALUSrcB/PCSource encodings SHALL live in shared package mips_pkg, also used by the ALU control decoder and datapath.
REQ-025 SHALL contain one state register plus combinational next-state logic; the output decode SHALL be sub-module mc_output_decode (inputs State, MemReady, reset; outputs all strobes/selects).

Verification
REQ-026 Reset, Opcode=100011, MemReady=1: State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-027 Opcode=101011, MemReady low 3 cycles in MEMWRITE: MemWrite=1, IorD=1 for 4 consecutive cycles, then FETCH; RegWrite never 1.
REQ-028 Opcode=000000 then 000100 then 000010: ALUOp=10 in EXECUTE, 01 in BRANCH with PCWriteCond=1, PCSource=10 with PCWrite=1 in JUMP; totals 4, 3, 3 cycles.
REQ-029 Opcode=111111: IllegalOp=1 for exactly one cycle in DECODE, next State=0, no MemWrite/RegWrite.
REQ-030 reset asserted while in MEMREAD with MemReady=0: next State=0, all outputs 0 during reset; after release, FETCH with MemRead=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, controller state codes, datapath select encodings
// and the control-word payload.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REGB    = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: instruction opcode and memory handshake in,
// strobes, mux selects and debug state out.
interface multicycle_control_if
  import mips_pkg::*;
  ();

  logic [OPCODE_W-1:0] Opcode;
  logic                MemReady;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegDst;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSource;
  logic                IllegalOp;
  logic [STATE_W-1:0]  State;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
  );

endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode for the multicycle controller; everything is forced low while reset is high.
module mc_output_decode
  import mips_pkg::*;
(
  input  logic [STATE_W-1:0] State,
  input  logic               MemReady,
  input  logic               reset,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state_t'(State))
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          // IR load and PC+4 commit only on the cycle memory returns the word
          ctrl.ir_write  = MemReady;
          ctrl.pc_write  = MemReady;
        end
        S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
        S_MEMADR, S_ADDIEXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ADDIWB: ctrl.reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state logic and illegal-opcode detect;
// datapath strobes come from mc_output_decode.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t state;
  state_t next_state;
  logic   illegal_op;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Opcode is only looked at in DECODE and MEMADR; the IR is stable elsewhere
  always_comb begin
    next_state = S_FETCH;
    illegal_op = 1'b0;
    case (state)
      S_FETCH:    next_state = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEXEC;
          default: begin
            next_state = S_FETCH;
            illegal_op = !reset;
          end
        endcase
      end
      S_MEMADR:   next_state = (bus.Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = bus.MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = bus.MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state = S_RTYPEWB;
      S_RTYPEWB:  next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_ADDIWB:   next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .State    (state),
    .MemReady (bus.MemReady),
    .reset    (reset),
    .ctrl     (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.IllegalOp   = illegal_op;
  assign bus.State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-level bench for multicycle_control against a per-instruction
// state-path and output-table reference model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],IllegalOp}
  function automatic logic [17:0] outs_now();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSource, bus.IllegalOp};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Output table, one row per state as listed in the controller requirements
  function automatic logic [17:0] exp_outs(input int st, input logic mr, input logic illegal);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, illo;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, illo} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; illo = illegal; end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rdst = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      9:  begin pcw = 1'b1; psrc = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: begin rw = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, illo};
  endfunction

  // One clock: drive inputs after the edge, check outputs before the next edge
  task automatic cycle(input int st, input logic mr, input logic [5:0] op, input string tag);
    @(posedge clk);
    #1;
    bus.MemReady = mr;
    bus.Opcode   = op;
    #3;
    check({tag, "_state"}, 32'(bus.State), 32'(st));
    check({tag, "_outs"}, 32'(outs_now()), 32'(exp_outs(st, mr, (st == 1) && !is_legal(op))));
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int   sq[$];
    logic mq[$];
    int   waits;
    logic [5:0] drv;
    for (int i = 0; i < fw; i++) begin sq.push_back(0); mq.push_back(1'b0); end
    sq.push_back(0); mq.push_back(1'b1);
    sq.push_back(1); mq.push_back(1'($urandom_range(0, 1)));
    waits = fw;
    case (op)
      6'b100011, 6'b101011: begin
        int mst;
        mst = (op == 6'b100011) ? 3 : 5;
        sq.push_back(2); mq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sq.push_back(mst); mq.push_back(1'b0); end
        sq.push_back(mst); mq.push_back(1'b1);
        if (op == 6'b100011) begin sq.push_back(4); mq.push_back(1'($urandom_range(0, 1))); end
        waits = fw + mw;
      end
      6'b000000: begin sq.push_back(6); sq.push_back(7); end
      6'b000100: sq.push_back(8);
      6'b000010: sq.push_back(9);
      6'b001000: begin sq.push_back(10); sq.push_back(11); end
      default: ;
    endcase
    while (mq.size() < sq.size()) mq.push_back(1'($urandom_range(0, 1)));
    check($sformatf("op%02h_latency", op), 32'(sq.size()), 32'(base_latency(op) + waits));
    for (int i = 0; i < sq.size(); i++) begin
      drv = ((sq[i] == 1) || (sq[i] == 2)) ? op : 6'($urandom);
      cycle(sq[i], mq[i], drv, $sformatf("op%02h_c%0d", op, i));
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[6];
    logic [5:0] op;
    int k;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    k = $urandom_range(0, 6);
    if (k < 6) return ops[k];
    do op = 6'($urandom); while (is_legal(op));
    return op;
  endfunction

  initial begin
    reset = 1'b1;
    bus.MemReady = 1'b1;
    bus.Opcode = 6'b000000;
    repeat (2) begin
      @(posedge clk);
      #4;
      check("reset_state", 32'(bus.State), 32'd0);
      check("reset_outs", 32'(outs_now()), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.MemReady = 1'b0;
    #3;
    check("release_state", 32'(bus.State), 32'd0);
    check("release_outs", 32'(outs_now()), 32'(exp_outs(0, 1'b0, 1'b0)));

    // Directed: lw, sw with 3 wait cycles, R-type, beq, j, illegal
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);

    // Reset while waiting in MEMREAD
    cycle(0, 1'b1, 6'b100011, "rst_mid_fetch");
    cycle(1, 1'b1, 6'b100011, "rst_mid_decode");
    cycle(2, 1'b1, 6'b100011, "rst_mid_memadr");
    cycle(3, 1'b0, 6'b100011, "rst_mid_memread0");
    cycle(3, 1'b0, 6'b100011, "rst_mid_memread1");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.MemReady = 1'b1;
    #3;
    check("rst_mid_assert_outs", 32'(outs_now()), 32'd0);
    @(posedge clk);
    #4;
    check("rst_mid_next_state", 32'(bus.State), 32'd0);
    check("rst_mid_hold_outs", 32'(outs_now()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.MemReady = 1'b0;
    #3;
    check("rst_mid_release_state", 32'(bus.State), 32'd0);
    check("rst_mid_release_memread", 32'(bus.MemRead), 32'd1);

    for (int n = 0; n < 200; n++)
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
